// File: rtl/conv_pkg.sv
// conv_pkg: state encoding, width helpers and the fixed-point
// round/ReLU/saturate step shared by the convolution blocks.
package conv_pkg;

    typedef enum logic [1:0] {
        LOAD_K   = 2'd0,
        LOAD_IMG = 2'd1,
        COMPUTE  = 2'd2,
        EMIT     = 2'd3
    } conv_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int acc_w(input int dw, input int k);
        return 2 * dw + clog2(k * k);
    endfunction

    // Round half up, optional ReLU, then clamp into a data_w signed word.
    function automatic logic signed [63:0] round_sat(
        input logic signed [63:0] acc,
        input int                 frac_w,
        input int                 data_w,
        input logic               relu
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (acc + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (relu && r < 64'sd0) r = 64'sd0;
        if (r > hi) r = hi;
        else if (r < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/conv2d_seq_engine_if.sv
// conv2d_seq_engine_if: kernel, pixel and result streams.
// master is the upstream/downstream side, slave is the engine.
interface conv2d_seq_engine_if #(
    parameter int DATA_W = 16
);
    logic              k_valid;
    logic [DATA_W-1:0] k_data;
    logic              k_ready;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    modport master (
        output k_valid, k_data, s_valid, s_data, m_ready,
        input  k_ready, s_ready, m_valid, m_data
    );

    modport slave (
        input  k_valid, k_data, s_valid, s_data, m_ready,
        output k_ready, s_ready, m_valid, m_data
    );
endinterface

// File: rtl/conv_mac_unit.sv
// conv_mac_unit: single multiply-accumulate with a registered
// finalize stage (round, ReLU, saturate) feeding the result word.
module conv_mac_unit
    import conv_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 36
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     first,
    input  logic                     fin,
    input  logic                     relu,
    input  logic signed [DATA_W-1:0] tap,
    input  logic signed [DATA_W-1:0] pix,
    output logic        [DATA_W-1:0] res
);
    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_in;
    logic signed [63:0]      acc64;
    logic signed [63:0]      r64;

    // The first tap overwrites the accumulator, so no separate clear cycle.
    always_comb begin
        prod   = PW'(tap) * PW'(pix);
        acc_in = first ? '0 : acc;
        acc64  = {{(64 - ACC_W){acc[ACC_W-1]}}, acc};
        r64    = round_sat(acc64, FRAC_W, DATA_W, relu);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            res <= '0;
        end else begin
            if (en) acc <= acc_in + {{(ACC_W - PW){prod[PW-1]}}, prod};
            if (fin) res <= r64[DATA_W-1:0];
        end
    end
endmodule

// File: rtl/conv2d_seq_engine.sv
// conv2d_seq_engine: time-multiplexed strided valid-mode 2-D convolution
// over streamed kernel and frame, one MAC, raster-order results.
module conv2d_seq_engine
    import conv_pkg::*;
#(
    parameter int IMG_W  = 5,
    parameter int IMG_H  = 5,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    conv2d_seq_engine_if.slave io,
    input  logic               k_load,
    input  logic               relu_en,
    output logic               busy,
    output logic               done
);
    localparam int KK    = K * K;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
    localparam int ACC_W = acc_w(DATA_W, K);
    localparam int TW    = clog2(KK);
    localparam int AW    = clog2(NPIX);
    localparam int CW    = clog2(KK + 1);
    localparam int KW    = clog2(K);
    localparam int XW    = clog2(OUT_W);
    localparam int YW    = clog2(OUT_H);

    localparam logic [TW-1:0] T_LAST  = TW'(KK - 1);
    localparam logic [AW-1:0] P_LAST  = AW'(NPIX - 1);
    localparam logic [CW-1:0] C_FIN   = CW'(KK);
    localparam logic [KW-1:0] KX_LAST = KW'(K - 1);
    localparam logic [XW-1:0] OX_LAST = XW'(OUT_W - 1);
    localparam logic [YW-1:0] OY_LAST = YW'(OUT_H - 1);

    conv_state_e state, state_nx;

    logic signed [DATA_W-1:0] kmem [KK];
    logic signed [DATA_W-1:0] pmem [NPIX];

    logic [TW-1:0] k_cnt, tap_addr;
    logic [AW-1:0] p_cnt, pix_addr;
    logic [CW-1:0] c_cnt;
    logic [KW-1:0] kx, ky;
    logic [XW-1:0] ox;
    logic [YW-1:0] oy;
    logic          relu_q;
    logic          kl_hit, k_fire, s_fire, m_fire;
    logic          last_pos, enter_c, mac_en, mac_fin;

    assign kl_hit   = k_load && (p_cnt == '0);
    assign k_fire   = (state == LOAD_K) && io.k_valid;
    assign s_fire   = (state == LOAD_IMG) && !kl_hit && io.s_valid;
    assign m_fire   = (state == EMIT) && io.m_ready;
    assign last_pos = (ox == OX_LAST) && (oy == OY_LAST);
    assign enter_c  = (state_nx == COMPUTE) && (state != COMPUTE);
    assign mac_en   = (state == COMPUTE) && (c_cnt != C_FIN);
    assign mac_fin  = (state == COMPUTE) && (c_cnt == C_FIN);

    assign tap_addr = TW'(int'(ky) * K + int'(kx));
    assign pix_addr = AW'((int'(oy) * STRIDE + int'(ky)) * IMG_W
                          + int'(ox) * STRIDE + int'(kx));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= LOAD_K;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        io.k_ready = 1'b0;
        io.s_ready = 1'b0;
        io.m_valid = 1'b0;
        busy       = 1'b0;
        unique case (state)
            LOAD_K: begin
                io.k_ready = 1'b1;
                if (io.k_valid && k_cnt == T_LAST) state_nx = LOAD_IMG;
            end
            LOAD_IMG: begin
                if (kl_hit) begin
                    state_nx = LOAD_K;
                end else begin
                    io.s_ready = 1'b1;
                    if (io.s_valid && p_cnt == P_LAST) state_nx = COMPUTE;
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                if (c_cnt == C_FIN) state_nx = EMIT;
            end
            EMIT: begin
                busy       = 1'b1;
                io.m_valid = 1'b1;
                if (io.m_ready) state_nx = last_pos ? LOAD_IMG : COMPUTE;
            end
            default: state_nx = LOAD_K;
        endcase
    end

    // Storage survives reset; only the counters restart.
    always_ff @(posedge clk) begin
        if (rst_n && k_fire) kmem[k_cnt] <= io.k_data;
        if (rst_n && s_fire) pmem[p_cnt] <= io.s_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_cnt  <= '0;
            p_cnt  <= '0;
            c_cnt  <= '0;
            kx     <= '0;
            ky     <= '0;
            ox     <= '0;
            oy     <= '0;
            relu_q <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (k_fire) k_cnt <= (k_cnt == T_LAST) ? '0 : k_cnt + 1'b1;
            if (s_fire) p_cnt <= (p_cnt == P_LAST) ? '0 : p_cnt + 1'b1;
            if (enter_c) relu_q <= relu_en;
            if (state == COMPUTE) begin
                c_cnt <= (c_cnt == C_FIN) ? '0 : c_cnt + 1'b1;
            end
            if (mac_en) begin
                if (kx == KX_LAST) begin
                    kx <= '0;
                    ky <= (ky == KX_LAST) ? '0 : ky + 1'b1;
                end else begin
                    kx <= kx + 1'b1;
                end
            end
            if (m_fire) begin
                if (ox == OX_LAST) begin
                    ox <= '0;
                    oy <= (oy == OY_LAST) ? '0 : oy + 1'b1;
                end else begin
                    ox <= ox + 1'b1;
                end
                if (last_pos) done <= 1'b1;
            end
        end
    end

    conv_mac_unit #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mac_en),
        .first (c_cnt == '0),
        .fin   (mac_fin),
        .relu  (relu_q),
        .tap   (kmem[tap_addr]),
        .pix   (pmem[pix_addr]),
        .res   (io.m_data)
    );
endmodule

// File: tb/tb_conv2d_seq_engine.sv
// tb_conv2d_seq_engine: directed and randomized frames checked
// against an arithmetic convolution model; two strided geometries.
module tb_conv2d_seq_engine;

    logic clk;
    logic rst_n;
    logic k_load;
    logic relu_en;
    logic busy;
    logic done;

    int n_chk;
    int n_pass;
    int done_cnt;
    bit geo_done [2];

    int kern  [64];
    int img   [64];
    int exp_v [16];

    conv2d_seq_engine_if #(.DATA_W(16)) bus ();

    conv2d_seq_engine #(
        .IMG_W(5), .IMG_H(5), .K(3), .STRIDE(1), .DATA_W(16), .FRAC_W(8)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .io      (bus),
        .k_load  (k_load),
        .relu_en (relu_en),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    function automatic int sx16(input int v);
        return int'(shortint'(v));
    endfunction

    // Plain arithmetic reference: floor((sum + half) / 2^8), ReLU, clamp.
    function automatic int model_px(input int kk [64], input int im [64],
                                    input int w, input int k, input int s,
                                    input int ox, input int oy, input bit relu);
        longint acc;
        longint r;
        acc = 0;
        for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++)
                acc += longint'(kk[ky * k + kx]) *
                       longint'(im[(oy * s + ky) * w + ox * s + kx]);
        acc += 128;
        if (acc >= 0) r = acc / 256;
        else r = -((-acc + 255) / 256);
        if (relu && r < 0) r = 0;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r) & 32'hFFFF;
    endfunction

    task automatic fill_exp(input bit relu);
        for (int oy = 0; oy < 3; oy++)
            for (int ox = 0; ox < 3; ox++)
                exp_v[oy * 3 + ox] = model_px(kern, img, 5, 3, 1, ox, oy, relu);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.k_valid = 1'b0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        k_load  = 1'b0;
        relu_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_k(input int v);
        int n;
        @(negedge clk);
        bus.k_valid = 1'b1;
        bus.k_data  = 16'(v);
        #1;
        n = 0;
        while (!bus.k_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.k_ready) check("k_ready_timeout", 0, 1);
        @(posedge clk);
        #1 bus.k_valid = 1'b0;
    endtask

    task automatic push_s(input int v);
        int n;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'(v);
        #1;
        n = 0;
        while (!bus.s_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.s_ready) check("s_ready_timeout", 0, 1);
        @(posedge clk);
        #1 bus.s_valid = 1'b0;
    endtask

    task automatic load_kernel();
        for (int i = 0; i < 9; i++) push_k(kern[i]);
    endtask

    task automatic reload_kernel();
        @(negedge clk);
        k_load = 1'b1;
        @(posedge clk);
        #1 k_load = 1'b0;
        load_kernel();
    endtask

    // late_kl raises k_load after the first pixel; it must be ignored.
    task automatic load_image(input bit late_kl);
        for (int i = 0; i < 25; i++) begin
            push_s(img[i]);
            if (late_kl && i == 0) k_load = 1'b1;
        end
        k_load = 1'b0;
    endtask

    task automatic collect(input int n, input string tag);
        int got;
        int cyc;
        int d0;
        got = 0;
        cyc = 0;
        d0  = done_cnt;
        while (got < n && cyc < 3000) begin
            @(negedge clk);
            bus.m_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.m_valid && bus.m_ready) begin
                check($sformatf("%s_px%0d", tag, got), int'(bus.m_data), exp_v[got]);
                got++;
            end
            cyc++;
        end
        @(posedge clk);
        #1 bus.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check($sformatf("%s_count", tag), got, n);
        check($sformatf("%s_done", tag), done_cnt - d0, 1);
        check($sformatf("%s_idle", tag), int'(bus.m_valid), 0);
    endtask

    task automatic rand_frame(input bit full, input string tag);
        bit r;
        for (int i = 0; i < 9; i++)
            kern[i] = full ? sx16(int'($urandom_range(0, 65535)))
                           : int'($urandom_range(0, 1023)) - 512;
        for (int i = 0; i < 25; i++) img[i] = sx16(int'($urandom_range(0, 65535)));
        r = 1'($urandom_range(0, 1));
        reload_kernel();
        relu_en = r;
        fill_exp(r);
        load_image(0);
        collect(9, tag);
    endtask

    task automatic const_frame(input int tap, input int px, input int res,
                               input bit relu, input bit reload, input string tag);
        for (int i = 0; i < 9; i++) kern[i] = sx16(tap);
        for (int i = 0; i < 25; i++) img[i] = sx16(px);
        for (int i = 0; i < 9; i++) exp_v[i] = res;
        if (reload) reload_kernel();
        relu_en = relu;
        load_image(0);
        collect(9, tag);
    endtask

    initial begin
        int cyc;
        int stable;
        int held;
        n_chk = 0;
        n_pass = 0;
        done_cnt = 0;
        rst_n = 1'b0;
        bus.k_valid = 1'b0;
        bus.k_data = '0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_ready = 1'b0;
        k_load = 1'b0;
        relu_en = 1'b0;
        do_reset();
        #1;
        check("rst_k_ready", int'(bus.k_ready), 1);
        check("rst_s_ready", int'(bus.s_ready), 0);
        check("rst_m_valid", int'(bus.m_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_m_data", int'(bus.m_data), 0);

        for (int i = 0; i < 9; i++) kern[i] = (i == 4) ? 256 : 0;
        for (int i = 0; i < 25; i++) img[i] = (i + 1) * 256;
        for (int oy = 0; oy < 3; oy++)
            for (int ox = 0; ox < 3; ox++)
                exp_v[oy * 3 + ox] = ((oy + 1) * 5 + ox + 2) * 256;
        load_kernel();
        load_image(0);
        check("ident_busy", int'(busy), 1);
        cyc = 0;
        while (!bus.m_valid && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", cyc, 10);
        check("hold_first", int'(bus.m_data), exp_v[0]);
        held = int'(bus.m_data);
        stable = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (bus.m_valid && int'(bus.m_data) == held) stable++;
        end
        check("hold_stable", stable, 20);
        collect(9, "ident");

        for (int i = 0; i < 25; i++) img[i] = sx16(int'($urandom_range(0, 65535)));
        fill_exp(0);
        load_image(0);
        collect(9, "reuse");

        @(negedge clk);
        k_load = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data = 16'h1234;
        #1;
        check("kload_s_ready", int'(bus.s_ready), 0);
        @(posedge clk);
        #1;
        check("kload_k_ready", int'(bus.k_ready), 1);
        k_load = 1'b0;
        bus.s_valid = 1'b0;
        for (int i = 0; i < 9; i++) kern[i] = int'($urandom_range(0, 1023)) - 512;
        for (int i = 0; i < 25; i++) img[i] = sx16(int'($urandom_range(0, 65535)));
        load_kernel();
        fill_exp(0);
        load_image(1);
        collect(9, "kload_frame");

        for (int f = 0; f < 4; f++) rand_frame(f[0], $sformatf("rand%0d", f));

        do_reset();
        #1;
        check("rst2_m_data", int'(bus.m_data), 0);
        check("rst2_k_ready", int'(bus.k_ready), 1);
        for (int i = 0; i < 9; i++) kern[i] = sx16(32'h7F00);
        load_kernel();
        const_frame(32'h7F00, 32'h7F00, 32'h7FFF, 0, 0, "sat_pos");
        const_frame(32'h8000, 32'h7F00, 32'h8000, 0, 1, "sat_neg");
        const_frame(32'hFF00, 32'h0100, 32'hF700, 0, 1, "neg_norelu");
        const_frame(32'hFF00, 32'h0100, 32'h0000, 1, 0, "neg_relu");

        for (int i = 0; i < 9; i++) kern[i] = (i == 4) ? 32'h80 : 0;
        for (int i = 0; i < 25; i++) img[i] = 1;
        for (int i = 0; i < 9; i++) exp_v[i] = 1;
        reload_kernel();
        relu_en = 1'b0;
        load_image(0);
        collect(9, "round");

        load_image(0);
        repeat (3) @(negedge clk);
        check("abort_busy", int'(busy), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_m_valid", int'(bus.m_valid), 0);
        check("abort_k_ready", int'(bus.k_ready), 1);
        rst_n = 1'b1;

        cyc = 0;
        while (!(geo_done[0] && geo_done[1]) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        if (!(geo_done[0] && geo_done[1])) check("geo_timeout", 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    for (genvar g = 0; g < 2; g++) begin : geo
        localparam int W    = (g == 0) ? 5 : 7;
        localparam int H    = (g == 0) ? 5 : 4;
        localparam int OW   = (g == 0) ? 2 : 3;
        localparam int NEXP = (g == 0) ? 4 : 3;

        logic g_rst_n;
        logic g_busy;
        logic g_done;

        conv2d_seq_engine_if #(.DATA_W(16)) gbus ();

        conv2d_seq_engine #(
            .IMG_W(W), .IMG_H(H), .K(3), .STRIDE(2), .DATA_W(16), .FRAC_W(8)
        ) u_geo (
            .clk     (clk),
            .rst_n   (g_rst_n),
            .io      (gbus),
            .k_load  (1'b0),
            .relu_en (1'b0),
            .busy    (g_busy),
            .done    (g_done)
        );

        initial begin
            int gk [64];
            int gi [64];
            int got;
            int cyc;
            int ndone;
            g_rst_n = 1'b0;
            gbus.k_valid = 1'b0;
            gbus.k_data = '0;
            gbus.s_valid = 1'b0;
            gbus.s_data = '0;
            gbus.m_ready = 1'b0;
            for (int i = 0; i < 64; i++) begin
                gk[i] = 0;
                gi[i] = 0;
            end
            repeat (3) @(negedge clk);
            g_rst_n = 1'b1;
            for (int i = 0; i < 9; i++) gk[i] = int'($urandom_range(0, 1023)) - 512;
            for (int i = 0; i < W * H; i++) gi[i] = sx16(int'($urandom_range(0, 65535)));
            for (int i = 0; i < 9 + W * H; i++) begin
                @(negedge clk);
                if (i < 9) begin
                    gbus.k_valid = 1'b1;
                    gbus.k_data = 16'(gk[i]);
                end else begin
                    gbus.s_valid = 1'b1;
                    gbus.s_data = 16'(gi[i - 9]);
                end
                @(posedge clk);
                #1;
                gbus.k_valid = 1'b0;
                gbus.s_valid = 1'b0;
            end
            gbus.m_ready = 1'b1;
            got = 0;
            cyc = 0;
            ndone = 0;
            while (cyc < 300) begin
                @(negedge clk);
                if (g_done) ndone++;
                if (gbus.m_valid) begin
                    if (got < NEXP)
                        check($sformatf("geo%0d_px%0d", g, got), int'(gbus.m_data),
                              model_px(gk, gi, W, 3, 2, got % OW, got / OW, 0));
                    got++;
                end
                cyc++;
            end
            check($sformatf("geo%0d_count", g), got, NEXP);
            check($sformatf("geo%0d_done", g), ndone, 1);
            geo_done[g] = 1'b1;
        end
    end

endmodule
